// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl
//   PC register and instruction-fetch controller sitting directly upstream of
//   the npc block. It holds the fetch PC, issues at most one request at a time
//   to instruction memory and presents each fetched word to decode over a
//   valid/ready handshake. When decode accepts an instruction, the PC advances
//   to npc (pc_change_i=1) or to pc+4. A flush redirect overrides everything.
//
// Parameters
//   RESET_PC          fetch PC loaded on reset
//
// Ports
//   clk_i             system clock, rising edge
//   reset_i           asynchronous, active-high reset
//   npc_i             next PC from the npc block, sampled only on accept
//   pc_change_i       1: take npc_i on accept, 0: take pc+4
//   flush_i           redirect/flush, highest priority
//   flush_pc_i        redirect target when flush_i=1
//   pc_o              current fetch PC (registered)
//   imem_req_o        one-cycle fetch request strobe
//   imem_addr_o       fetch address (equals pc_o)
//   imem_rvalid_i     memory response valid, in order, >=1 cycle after request
//   imem_rdata_i      instruction word returned by memory
//   inst_valid_o      inst_o/inst_pc_o valid towards decode
//   inst_ready_i      decode accepts when inst_valid_o & inst_ready_i
//   inst_o            registered instruction word
//   inst_pc_o         PC of inst_o
//   fetch_misalign_o  one-cycle pulse after a target with bits[1:0]!=0 is loaded

module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] npc_i,
  input  logic        pc_change_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [31:0] pc_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        fetch_misalign_o
);

  // DROP means a response is still owed by memory but belongs to a PC that
  // has since been redirected away from, so it must be swallowed.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        misalign_q, misalign_d;

  // State and datapath registers; everything returns to its reset value
  // immediately when reset_i rises.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  // Next-state logic. A flush wins over everything, including an accept in
  // the same cycle. Loaded targets are forced word-aligned and the misalign
  // flag is registered so it pulses in the cycle after the load.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    misalign_d   = 1'b0;

    if (flush_i) begin
      pc_d         = {flush_pc_i[31:2], 2'b00};
      misalign_d   = (flush_pc_i[1:0] != 2'b00);
      inst_valid_d = 1'b0;
      case (state_q)
        // The request issued this cycle is still owed by memory.
        FETCH:   state_d = DROP;
        // A response arriving together with the flush is simply dropped.
        WAIT:    state_d = imem_rvalid_i ? FETCH : DROP;
        // Stay in DROP until the stale response arrives; if it arrives now
        // nothing is outstanding any more and fetching can restart.
        DROP:    state_d = imem_rvalid_i ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: state_d = WAIT;
        WAIT: begin
          if (imem_rvalid_i) begin
            inst_d       = imem_rdata_i;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          if (inst_ready_i) begin
            inst_valid_d = 1'b0;
            state_d      = FETCH;
            if (pc_change_i) begin
              pc_d       = {npc_i[31:2], 2'b00};
              misalign_d = (npc_i[1:0] != 2'b00);
            end else begin
              pc_d       = pc_q + 32'd4;
            end
          end
        end
        DROP: begin
          if (imem_rvalid_i) begin
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pc_o             = pc_q;
  assign imem_req_o       = (state_q == FETCH);
  assign imem_addr_o      = pc_q;
  assign inst_valid_o     = inst_valid_q;
  assign inst_o           = inst_q;
  assign inst_pc_o        = inst_pc_q;
  assign fetch_misalign_o = misalign_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl
//   Self-checking bench for ifetch_ctrl. A single stimulus task advances one
//   cycle at a time: at each falling edge it checks the DUT outputs against a
//   scoreboard (expected fetch addresses and expected instructions held in
//   queues), plays an instruction memory with configurable latency, and drives
//   the next set of inputs.

module tb_ifetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc;
  logic        pcChange;
  logic        flush;
  logic [31:0] flushPc;
  logic [31:0] pc;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        instValid;
  logic        instReady;
  logic [31:0] inst;
  logic [31:0] instPc;
  logic        fetchMisalign;

  ifetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .npc_i            (npc),
    .pc_change_i      (pcChange),
    .flush_i          (flush),
    .flush_pc_i       (flushPc),
    .pc_o             (pc),
    .imem_req_o       (imemReq),
    .imem_addr_o      (imemAddr),
    .imem_rvalid_i    (imemRvalid),
    .imem_rdata_i     (imemRdata),
    .inst_valid_o     (instValid),
    .inst_ready_i     (instReady),
    .inst_o           (inst),
    .inst_pc_o        (instPc),
    .fetch_misalign_o (fetchMisalign)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } instExp_t;

  instExp_t    instQ[$];
  logic [31:0] addrQ[$];

  int          vectors     = 0;
  int          miscompares = 0;

  int          memLat   = 1;
  int          memCnt   = 0;
  bit          memPend  = 1'b0;
  bit          memStale = 1'b0;
  logic [31:0] memAddr  = 32'h0;
  bit          junkRvalid = 1'b0;
  bit          reqSeen    = 1'b0;
  logic        misExp     = 1'b0;
  logic [31:0] expPc      = RESET_PC;

  // Memory contents: address 0x3000 holds 0x2408000A.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h2408_300A;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // One cycle: check outputs at the falling edge, update the model, run the
  // memory, then drive the inputs the DUT samples at the next rising edge.
  task automatic applyStimulus(input bit ready, input bit doFlush,
                               input logic [31:0] fpc, input bit chg,
                               input logic [31:0] npcVal);
    bit          accept;
    bit          rv;
    logic [31:0] rd;
    logic [31:0] expAddr;
    instExp_t    head;
    @(negedge clk);
    accept  = 1'b0;
    reqSeen = 1'b0;
    checkOutput("pc", pc, expPc);
    checkOutput("fetch_misalign", 32'(fetchMisalign), 32'(misExp));
    checkOutput("inst_valid", 32'(instValid), 32'(instQ.size() != 0));
    if (instQ.size() != 0) begin
      head = instQ[0];
      checkOutput("inst", inst, head.word);
      checkOutput("inst_pc", instPc, head.pc);
      accept = ready && !doFlush;
    end
    expAddr = 32'hx;
    if (imemReq) begin
      reqSeen = 1'b1;
      if (addrQ.size() != 0) expAddr = addrQ.pop_front();
      checkOutput("imem_addr", imemAddr, expAddr);
    end

    misExp = 1'b0;
    if (accept) begin
      head  = instQ.pop_front();
      expPc = chg ? {npcVal[31:2], 2'b00} : head.pc + 32'd4;
      addrQ.push_back(expPc);
      misExp = chg && (npcVal[1:0] != 2'b00);
    end
    if (doFlush) begin
      instQ.delete();
      addrQ.delete();
      expPc = {fpc[31:2], 2'b00};
      addrQ.push_back(expPc);
      misExp = (fpc[1:0] != 2'b00);
    end

    rv = 1'b0;
    rd = 32'hDEAD_BEEF;
    if (memPend) begin
      memCnt--;
      if (memCnt == 0) begin
        rv      = 1'b1;
        rd      = memWord(memAddr);
        memPend = 1'b0;
        if (!memStale && !doFlush) instQ.push_back('{word: rd, pc: memAddr});
      end
    end
    if (imemReq) begin
      memPend  = 1'b1;
      memCnt   = memLat;
      memAddr  = expAddr;
      memStale = 1'b0;
    end
    if (doFlush && memPend) memStale = 1'b1;
    if (!rv && junkRvalid) begin
      rv = 1'b1;
      rd = 32'hBAD0_BAD0;
    end

    instReady  = ready;
    flush      = doFlush;
    flushPc    = fpc;
    pcChange   = chg;
    npc        = npcVal;
    imemRvalid = rv;
    imemRdata  = rd;
  endtask

  task automatic idleStep(input bit ready);
    applyStimulus(ready, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic waitValid(input int maxSteps);
    int n = 0;
    while (instQ.size() == 0 && n < maxSteps) begin
      idleStep(1'b0);
      n++;
    end
    if (instQ.size() == 0) checkOutput("valid_timeout", 32'(instValid), 32'd1);
  endtask

  task automatic runUntilReq(input int maxSteps, input bit ready);
    int n = 0;
    reqSeen = 1'b0;
    while (!reqSeen && n < maxSteps) begin
      idleStep(ready);
      n++;
    end
    if (!reqSeen) checkOutput("req_timeout", 32'(imemReq), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pc"}, pc, RESET_PC);
    checkOutput({tag, "_imem_req"}, 32'(imemReq), 32'd0);
    checkOutput({tag, "_inst_valid"}, 32'(instValid), 32'd0);
    checkOutput({tag, "_inst"}, inst, 32'h0);
    checkOutput({tag, "_inst_pc"}, instPc, RESET_PC);
    checkOutput({tag, "_misalign"}, 32'(fetchMisalign), 32'd0);
  endtask

  task automatic clearModel();
    instQ.delete();
    addrQ.delete();
    memPend    = 1'b0;
    memStale   = 1'b0;
    memCnt     = 0;
    junkRvalid = 1'b0;
    misExp     = 1'b0;
    expPc      = RESET_PC;
  endtask

  // Directed scenarios: basic fetch, decode stall, npc/pc+4 redirect, flush
  // during an outstanding request, flush against an accept, misaligned and
  // wrapping targets, and an asynchronous reset in the middle of a fetch.
  initial begin
    reset      = 1'b1;
    npc        = 32'h0;
    pcChange   = 1'b0;
    flush      = 1'b0;
    flushPc    = 32'h0;
    imemRvalid = 1'b0;
    imemRdata  = 32'h0;
    instReady  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;
    addrQ.push_back(RESET_PC);

    // First request one cycle after reset release, instruction two later.
    idleStep(1'b1);
    checkOutput("first_req", 32'(reqSeen), 32'd1);
    idleStep(1'b1);
    idleStep(1'b1);
    idleStep(1'b1);
    checkOutput("second_req_3cyc", 32'(reqSeen), 32'd1);

    // Decode stall with spurious rvalid pulses that must be ignored.
    waitValid(10);
    junkRvalid = 1'b1;
    repeat (5) idleStep(1'b0);
    junkRvalid = 1'b0;
    idleStep(1'b1);

    // npc redirect, then sequential pc+4.
    waitValid(10);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3040);
    runUntilReq(5, 1'b0);
    waitValid(10);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    runUntilReq(5, 1'b0);

    // Flush while a slow response is outstanding.
    waitValid(10);
    memLat = 4;
    idleStep(1'b1);
    runUntilReq(5, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_4180, 1'b0, 32'h0);
    memLat = 1;
    runUntilReq(10, 1'b1);

    // Flush coinciding with an accept that requests an npc change.
    waitValid(10);
    applyStimulus(1'b1, 1'b1, 32'h0000_4180, 1'b1, 32'h0000_3040);
    runUntilReq(5, 1'b0);

    // Misaligned npc, then wrap from the top of the address space.
    waitValid(10);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3042);
    idleStep(1'b0);
    waitValid(10);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    runUntilReq(5, 1'b0);
    waitValid(10);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    runUntilReq(5, 1'b0);

    // Asynchronous reset while waiting for the response.
    idleStep(1'b0);
    #2 reset = 1'b1;
    #1 checkResetOutputs("async_reset");
    clearModel();
    imemRvalid = 1'b0;
    flush      = 1'b0;
    instReady  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    addrQ.push_back(RESET_PC);
    runUntilReq(5, 1'b1);
    waitValid(10);
    idleStep(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
